// File: rtl/led_blink_scheduler_pkg.sv
// Shared types and constants for the LED blink scheduler: rate codes, FSM states, half-period math.
package led_blink_pkg;

    localparam int unsigned FREQ_100 = 100;
    localparam int unsigned FREQ_50  = 50;
    localparam int unsigned FREQ_10  = 10;
    localparam int unsigned FREQ_1   = 1;

    typedef enum logic [1:0] {
        RATE_100 = 2'b00,
        RATE_50  = 2'b01,
        RATE_10  = 2'b10,
        RATE_1   = 2'b11
    } rate_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_ON,
        ST_OFF
    } state_e;

    function automatic int unsigned half_count(input int unsigned clk_hz, input rate_e rate);
        int unsigned freq;
        case (rate)
            RATE_100: freq = FREQ_100;
            RATE_50:  freq = FREQ_50;
            RATE_10:  freq = FREQ_10;
            default:  freq = FREQ_1;
        endcase
        return clk_hz / (2 * freq);
    endfunction

endpackage

// File: rtl/led_blink_scheduler_if.sv
// Requester-side bundle of the LED scheduler; master drives requests, slave is the scheduler.
interface led_blink_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic                   i_enable;
    logic [NUM_REQ-1:0]     i_req;
    logic [2*NUM_REQ-1:0]   i_rate;
    logic                   o_led_drive;
    logic [NUM_REQ-1:0]     o_grant;
    logic                   o_busy;

    modport master (
        output i_enable, i_req, i_rate,
        input  o_led_drive, o_grant, o_busy
    );

    modport slave (
        input  i_enable, i_req, i_rate,
        output o_led_drive, o_grant, o_busy
    );
endinterface

// File: rtl/led_blink_scheduler_rate_divider.sv
// Half-period counter: counts 0..HALF-1 for the selected rate, terminal is combinational at HALF-1.
// Clear holds the count at zero; no backpressure, it free-runs whenever not cleared.
module led_rate_divider
    import led_blink_pkg::*;
#(
    parameter int unsigned CLK_HZ = 25000000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  rate_e rate,
    output logic  terminal
);
    localparam int unsigned W = $clog2(CLK_HZ / 2);

    localparam logic [W-1:0] LAST_100 = W'(half_count(CLK_HZ, RATE_100) - 1);
    localparam logic [W-1:0] LAST_50  = W'(half_count(CLK_HZ, RATE_50)  - 1);
    localparam logic [W-1:0] LAST_10  = W'(half_count(CLK_HZ, RATE_10)  - 1);
    localparam logic [W-1:0] LAST_1   = W'(half_count(CLK_HZ, RATE_1)   - 1);

    logic [W-1:0] cnt;
    logic [W-1:0] last_cnt;

    always_comb begin
        last_cnt = LAST_100;
        case (rate)
            RATE_100: last_cnt = LAST_100;
            RATE_50:  last_cnt = LAST_50;
            RATE_10:  last_cnt = LAST_10;
            RATE_1:   last_cnt = LAST_1;
            default:  last_cnt = LAST_100;
        endcase
    end

    assign terminal = !clear && (cnt == last_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == last_cnt) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of the board LED; blinks the granted rate for HOLD_PERIODS periods per grant.
// Outputs are registered, grant/LED rise 2 cycles after a request is seen; requesters simply wait.
module led_blink_scheduler
    import led_blink_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 25000000,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned HOLD_PERIODS = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    led_blink_scheduler_if.slave bus
);
    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PW = $clog2(HOLD_PERIODS + 1);

    state_e             state, state_d;
    logic [OW-1:0]      last_owner, last_owner_d;
    rate_e              rate_q, rate_d;
    logic [PW-1:0]      period_cnt, period_cnt_d;
    logic [NUM_REQ-1:0] grant_d;
    logic               led_d;
    logic               any_req, found, terminal, div_clear;
    logic [OW-1:0]      pick, cand;

    assign any_req = |bus.i_req;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = last_owner;
        cand  = last_owner;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = OW'((int'(last_owner) + i) % int'(NUM_REQ));
            if (!found && bus.i_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d      = state;
        last_owner_d = last_owner;
        rate_d       = rate_q;
        period_cnt_d = period_cnt;
        if (!bus.i_enable) begin
            state_d      = ST_IDLE;
            period_cnt_d = '0;
        end else begin
            case (state)
                ST_IDLE: if (any_req) state_d = ST_ARB;
                ST_ARB: begin
                    period_cnt_d = '0;
                    if (found) begin
                        state_d      = ST_ON;
                        last_owner_d = pick;
                        rate_d       = rate_e'(bus.i_rate[{pick, 1'b0} +: 2]);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ON: if (terminal) state_d = ST_OFF;
                ST_OFF: begin
                    if (terminal) begin
                        if (period_cnt == PW'(HOLD_PERIODS - 1) || !bus.i_req[last_owner]) begin
                            state_d      = any_req ? ST_ARB : ST_IDLE;
                            period_cnt_d = '0;
                        end else begin
                            state_d      = ST_ON;
                            period_cnt_d = period_cnt + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decode the next state so they change on the same edge as the FSM.
    assign led_d   = (state_d == ST_ON);
    assign grant_d = (state_d == ST_ON || state_d == ST_OFF) ? (NUM_REQ'(1) << last_owner_d) : '0;

    assign div_clear = !bus.i_enable || !(state == ST_ON || state == ST_OFF);

    led_rate_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_divider (
        .clk      (i_clock),
        .rst      (i_reset),
        .clear    (div_clear),
        .rate     (rate_q),
        .terminal (terminal)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            last_owner      <= OW'(NUM_REQ - 1);
            rate_q          <= RATE_100;
            period_cnt      <= '0;
            bus.o_led_drive <= 1'b0;
            bus.o_grant     <= '0;
            bus.o_busy      <= 1'b0;
        end else begin
            state           <= state_d;
            last_owner      <= last_owner_d;
            rate_q          <= rate_d;
            period_cnt      <= period_cnt_d;
            bus.o_led_drive <= led_d;
            bus.o_grant     <= grant_d;
            bus.o_busy      <= |grant_d;
        end
    end
endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler at CLK_HZ=1000 (HALF = 5/10/50/500), NUM_REQ=4, HOLD_PERIODS=2.
module tb_led_blink_scheduler;

    typedef struct packed {
        logic [3:0] grant;
        int         high;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic [7:0] rate;
        int         first;
        int         n;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   bad_cycles = 0;
    exp_t sb_q[$];
    row_t rows[4];
    exp_t exp_tab[18];

    led_blink_scheduler_if #(.NUM_REQ(4)) bus ();

    led_blink_scheduler #(
        .CLK_HZ       (1000),
        .NUM_REQ      (4),
        .HOLD_PERIODS (2)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Structural invariants sampled every cycle: never two-hot, busy tracks grant, LED only with an owner.
    always @(negedge clk) begin
        if (!rst) begin
            if (!$onehot0(bus.o_grant) || (bus.o_busy != (|bus.o_grant)) ||
                (bus.o_led_drive && bus.o_grant == 4'b0000))
                bad_cycles++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic wait_led_high(input int bound, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.o_led_drive) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    task automatic run_len(input logic val, output int n);
        n = 0;
        while (bus.o_led_drive == val && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int bound, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!bus.o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    // Measures each LED pulse and pops the scoreboard on its falling sample.
    task automatic sb_run(input int bound, input bit until_idle, input string name);
        int         hcnt = 0;
        logic [3:0] hg = 4'b0000;
        bit         done = 1'b0;
        exp_t       e;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (bus.o_led_drive) begin
                if (hcnt == 0) hg = bus.o_grant;
                hcnt++;
            end else if (hcnt != 0) begin
                if (sb_q.size() == 0) begin
                    check({name, "_unexpected_pulse_len"}, hcnt, 0);
                end else begin
                    e = sb_q.pop_front();
                    check({name, "_grant"}, int'(hg), int'(e.grant));
                    check({name, "_high"}, hcnt, e.high);
                end
                hcnt = 0;
            end
            if (!until_idle && sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            if (until_idle && !bus.o_busy && !bus.o_led_drive) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout(name);
    endtask

    initial begin
        int n;
        int m;

        rows[0] = '{req: 4'b0100, rate: 8'h10, first: 0,  n: 4};
        rows[1] = '{req: 4'b1001, rate: 8'h80, first: 4,  n: 4};
        rows[2] = '{req: 4'b0010, rate: 8'h0C, first: 8,  n: 2};
        rows[3] = '{req: 4'b1111, rate: 8'h24, first: 10, n: 8};
        exp_tab = '{
            '{4'b0100, 10}, '{4'b0100, 10}, '{4'b0100, 10}, '{4'b0100, 10},
            '{4'b1000, 50}, '{4'b1000, 50}, '{4'b0001, 5},  '{4'b0001, 5},
            '{4'b0010, 500}, '{4'b0010, 500},
            '{4'b0100, 50}, '{4'b0100, 50}, '{4'b1000, 5},  '{4'b1000, 5},
            '{4'b0001, 5},  '{4'b0001, 5},  '{4'b0010, 10}, '{4'b0010, 10}
        };

        bus.i_enable = 1'b0;
        bus.i_req    = 4'b0000;
        bus.i_rate   = 8'h00;

        #12;
        check("reset_led", int'(bus.o_led_drive), 0);
        check("reset_grant", int'(bus.o_grant), 0);
        check("reset_busy", int'(bus.o_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_enable = 1'b1;
        @(negedge clk);

        // Sole requester: 2-cycle grant latency, two 10/10 periods, one ARB gap, regrant.
        bus.i_req  = 4'b0100;
        bus.i_rate = 8'h10;
        @(negedge clk);
        check("lat_arb_grant", int'(bus.o_grant), 0);
        check("lat_arb_led", int'(bus.o_led_drive), 0);
        @(negedge clk);
        check("lat_on_led", int'(bus.o_led_drive), 1);
        check("lat_on_grant", int'(bus.o_grant), 4'b0100);
        check("lat_on_busy", int'(bus.o_busy), 1);
        for (int t = 1; t <= 41; t++) begin
            @(negedge clk);
            if (t == 9)  check("sole_t9_led", int'(bus.o_led_drive), 1);
            if (t == 10) check("sole_t10_led", int'(bus.o_led_drive), 0);
            if (t == 39) check("sole_t39_grant", int'(bus.o_grant), 4'b0100);
            if (t == 40) check("sole_arb_grant", int'(bus.o_grant), 0);
            if (t == 40) check("sole_arb_led", int'(bus.o_led_drive), 0);
            if (t == 41) check("sole_regrant", int'(bus.o_grant), 4'b0100);
            if (t == 41) check("sole_regrant_led", int'(bus.o_led_drive), 1);
        end
        bus.i_req = 4'b0000;
        run_len(1'b1, n);
        check("sole_drop_high", n, 10);
        wait_idle(40, "sole_drop_idle");
        check("sole_drop_led", int'(bus.o_led_drive), 0);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < rows[r].n; k++) sb_q.push_back(exp_tab[rows[r].first + k]);
            bus.i_req  = rows[r].req;
            bus.i_rate = rows[r].rate;
            sb_run(5000, 1'b0, $sformatf("row%0d", r));
            bus.i_req = 4'b0000;
            sb_run(2000, 1'b1, $sformatf("row%0d_tail", r));
            check($sformatf("row%0d_idle_led", r), int'(bus.o_led_drive), 0);
        end
        check("sb_left", sb_q.size(), 0);

        // Rate changed mid-grant only takes effect at the next ARB.
        bus.i_req  = 4'b0001;
        bus.i_rate = 8'h00;
        wait_led_high(10, "rate_first");
        check("rate_grant", int'(bus.o_grant), 4'b0001);
        bus.i_rate = 8'h01;
        run_len(1'b1, n); check("rate_h1", n, 5);
        run_len(1'b0, n); check("rate_l1", n, 5);
        run_len(1'b1, n); check("rate_h2", n, 5);
        run_len(1'b0, n); check("rate_l2_arb", n, 6);
        run_len(1'b1, n); check("rate_h_new", n, 10);
        check("rate_grant_new", int'(bus.o_grant), 4'b0001);
        bus.i_req = 4'b0000;
        wait_idle(50, "rate_idle");

        // Enable dropped mid-ON, then resumed past the prior owner.
        bus.i_req  = 4'b1111;
        bus.i_rate = 8'h00;
        wait_led_high(10, "en_first");
        check("en_grant", int'(bus.o_grant), 4'b0010);
        @(negedge clk);
        bus.i_enable = 1'b0;
        @(negedge clk);
        check("en_off_led", int'(bus.o_led_drive), 0);
        check("en_off_grant", int'(bus.o_grant), 0);
        check("en_off_busy", int'(bus.o_busy), 0);
        @(negedge clk);
        @(negedge clk);
        bus.i_enable = 1'b1;
        wait_led_high(10, "en_resume");
        check("en_resume_grant", int'(bus.o_grant), 4'b0100);

        // Asynchronous reset mid-OFF, first grant afterwards goes to the lowest requester.
        run_len(1'b1, n);
        check("arst_pre_high", n, 5);
        #1 rst = 1'b1;
        bus.i_req = 4'b1100;
        #1;
        check("arst_led", int'(bus.o_led_drive), 0);
        check("arst_grant", int'(bus.o_grant), 0);
        check("arst_busy", int'(bus.o_busy), 0);
        #1 rst = 1'b0;
        wait_led_high(10, "arst_first");
        check("arst_first_grant", int'(bus.o_grant), 4'b0100);

        // Request dropped mid-ON: period completes, LED ends low, then idle.
        bus.i_req = 4'b0010;
        m = 0;
        while (!(bus.o_led_drive && bus.o_grant == 4'b0010) && m < 60) begin
            m++;
            @(negedge clk);
        end
        if (m >= 60) timeout("drop_wait_grant");
        @(negedge clk);
        bus.i_req = 4'b0000;
        run_len(1'b1, n);
        check("drop_rest_high", n, 4);
        m = 0;
        while (bus.o_busy && m < 100) begin
            m++;
            @(negedge clk);
        end
        check("drop_low_busy", m, 5);
        check("drop_idle_busy", int'(bus.o_busy), 0);
        check("drop_idle_led", int'(bus.o_led_drive), 0);
        check("drop_idle_grant", int'(bus.o_grant), 0);

        check("invariant_cycles", bad_cycles, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
